// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per clock, valid/ready in and out.
// Optional macro MDU_EARLY_OUT_EN: divide-by-zero, signed overflow and zero multiplies finish one edge after accept.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam int CNT_W = $clog2(XLEN + 1);

  logic [1:0]        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic              early_q, early_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   out_result_q, out_result_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
    return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
  endfunction

  // Operand decode at accept: signedness per op, then magnitudes
  logic            in_div, sgn_a, sgn_b, neg_a, neg_b;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    in_div = in_op[2];
    sgn_a  = in_div ? ~in_op[0] : (in_op != 3'b011);
    sgn_b  = in_div ? ~in_op[0] : ~in_op[1];
    neg_a  = sgn_a & in_a[XLEN-1];
    neg_b  = sgn_b & in_b[XLEN-1];
    a_mag  = neg_a ? neg_x(in_a) : in_a;
    b_mag  = neg_b ? neg_x(in_b) : in_b;
  end

  logic            early_hit;
  logic [XLEN-1:0] early_res;

`ifdef MDU_EARLY_OUT_EN
  always_comb begin
    early_hit = 1'b0;
    early_res = '0;
    if (in_op[2]) begin
      if (in_b == '0) begin
        early_hit = 1'b1;
        early_res = in_op[1] ? in_a : '1;
      end else if (!in_op[0] && in_a == {1'b1, {(XLEN-1){1'b0}}} && in_b == '1) begin
        early_hit = 1'b1;
        early_res = in_op[1] ? '0 : in_a;
      end
    end else if (in_a == '0 || in_b == '0) begin
      early_hit = 1'b1;
      early_res = '0;
    end
  end
`else
  always_comb begin
    early_hit = 1'b0;
    early_res = '0;
  end
`endif

  // One iteration step: shift-add multiply, restoring divide
  logic [XLEN:0]     mul_sum, rem_sh, diff;
  logic [2*XLEN-1:0] mul_next, div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : {XLEN{1'b0}})};
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    diff     = rem_sh - {1'b0, opnd_q};
    div_next = diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                          : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  // Sign correction and result select; a zero divisor keeps the all-ones quotient
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_res;

  always_comb begin
    prod = (sa_q ^ sb_q) ? neg_2x(acc_q) : acc_q;
    quo  = ((sa_q ^ sb_q) && opnd_q != '0) ? neg_x(acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    rem  = sa_q ? neg_x(acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                 fix_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quo;
      default:                fix_res = rem;
    endcase
    if (early_q) fix_res = acc_q[XLEN-1:0];
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    tag_d        = tag_q;
    opnd_d       = opnd_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    sa_d         = sa_q;
    sb_d         = sb_q;
    early_d      = early_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = early_hit ? S_FIX : S_BUSY;
          op_d    = in_op;
          tag_d   = in_tag;
          sa_d    = neg_a;
          sb_d    = neg_b;
          early_d = early_hit;
          cnt_d   = '0;
          opnd_d  = in_div ? b_mag : a_mag;
          acc_d   = {{XLEN{1'b0}}, (early_hit ? early_res : (in_div ? a_mag : b_mag))};
        end
      end
      S_BUSY: begin
        // A final settle cycle after the last iteration gives XLEN+2 total latency
        if (cnt_q == CNT_W'(XLEN)) begin
          state_d = S_FIX;
        end else begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FIX: begin
        out_result_d = fix_res;
        out_tag_d    = tag_q;
        out_valid_d  = 1'b1;
        state_d      = S_DONE;
      end
      default: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
    endcase
    if (flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      tag_q        <= '0;
      opnd_q       <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      sa_q         <= 1'b0;
      sb_q         <= 1'b0;
      early_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      tag_q        <= tag_d;
      opnd_q       <= opnd_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      sa_q         <= sa_d;
      sb_q         <= sb_d;
      early_q      <= early_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed plus randomized bench for muldiv_unit with a result/tag/latency scoreboard.
module tb_muldiv_unit;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam int LAT   = XLEN + 2;
`ifdef MDU_EARLY_OUT_EN
  localparam int SP_LAT = 1;
`else
  localparam int SP_LAT = LAT;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_op = '0;
  logic [XLEN-1:0]  in_a = '0;
  logic [XLEN-1:0]  in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  int n_pass  = 0;
  int n_total = 0;

  logic [XLEN-1:0]  exp_res_q[$];
  logic [TAG_W-1:0] exp_tag_q[$];
  int               exp_lat_q[$];

  muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
  endtask

  function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    ea = (op == 3'b011) ? {32'b0, a} : {{32{a[31]}}, a};
    eb = op[1] ? {32'b0, b} : {{32{b[31]}}, b};
    p  = ea * eb;
    case (op)
      3'b000:                 return p[31:0];
      3'b001, 3'b010, 3'b011: return p[63:32];
      3'b100:  return (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb);
      3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110:  return (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit sp;
    if (op[2]) sp = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    else       sp = (a == 0) || (b == 0);
    return sp ? SP_LAT : LAT;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp);
    int w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_res_q.push_back(exp);
    exp_tag_q.push_back(tag);
    exp_lat_q.push_back(lat_of(op, a, b));
  endtask

  task automatic collect(input string name, input bit release_now);
    int lat = 0;
    bit ready_seen = 0;
    logic [31:0] er;
    logic [4:0]  et;
    int el;
    while (!out_valid && lat < 200) begin
      if (in_ready) ready_seen = 1;
      @(posedge clk); #1;
      lat++;
    end
    er = exp_res_q.pop_front();
    et = exp_tag_q.pop_front();
    el = exp_lat_q.pop_front();
    chk({name, " latency"}, 64'(lat), 64'(el));
    chk({name, " result"}, 64'(out_result), 64'(er));
    chk({name, " tag"}, 64'(out_tag), 64'(et));
    chk({name, " in_ready low while busy"}, 64'(ready_seen | in_ready), 64'd0);
    if (release_now) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({name, " out_valid drop"}, 64'(out_valid), 64'd0);
      chk({name, " in_ready back"}, 64'(in_ready), 64'd1);
    end
  endtask

  task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp);
    issue(op, a, b, tag, exp);
    collect(name, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    bit          seen;

    #2 rst_n = 1'b0;
    #1;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_result", 64'(out_result), 64'd0);
    chk("reset out_tag", 64'(out_tag), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run("MUL", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
    run("MULH", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000);
    run("MULHU", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE);
    run("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'hFFFF_FFFF);
    run("DIV", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD);
    run("REM", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF);
    run("DIVU", 3'b101, 32'd100, 32'd7, 5'd7, 32'd14);
    run("REMU", 3'b111, 32'd100, 32'd7, 5'd8, 32'd2);

    run("DIV by zero", 3'b100, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF);
    run("REM by zero", 3'b110, 32'd5, 32'd0, 5'd11, 32'd5);
    run("DIV neg by zero", 3'b100, 32'hFFFF_FFFB, 32'd0, 5'd12, 32'hFFFF_FFFF);
    run("REM neg by zero", 3'b110, 32'hFFFF_FFFB, 32'd0, 5'd13, 32'hFFFF_FFFB);
    run("DIVU by zero", 3'b101, 32'd9, 32'd0, 5'd14, 32'hFFFF_FFFF);
    run("DIV overflow", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000);
    run("REM overflow", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0);
    run("MUL by zero", 3'b000, 32'd0, 32'h1234_5678, 5'd17, 32'd0);

    for (int i = 0; i < 12; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i == 3) ? 32'd0 : $urandom;
      run("random", rop, ra, rb, 5'($urandom_range(0, 31)), ref_mdu(rop, ra, rb));
    end

    // Backpressure: result must hold and new requests must be ignored
    issue(3'b000, 32'd1000, 32'd3, 5'd9, 32'd3000);
    collect("backpressure", 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_op = 3'b101; in_a = $urandom; in_b = $urandom; in_tag = 5'd21;
      @(posedge clk); #1;
      chk("bp hold valid", 64'(out_valid), 64'd1);
      chk("bp hold result", 64'(out_result), 64'd3000);
      chk("bp hold tag", 64'(out_tag), 64'd9);
      chk("bp in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp release valid", 64'(out_valid), 64'd0);
    chk("bp release in_ready", 64'(in_ready), 64'd1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("bp no stray accept", 64'(in_ready), 64'd1);

    // Flush on the 10th BUSY cycle
    issue(3'b000, 32'd11, 32'd13, 5'd19, 32'd143);
    exp_res_q.delete(); exp_tag_q.delete(); exp_lat_q.delete();
    repeat (9) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush idle", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1;
      @(posedge clk); #1;
    end
    chk("flush no out_valid", 64'(seen | out_valid), 64'd0);

    // Asynchronous reset mid-BUSY
    issue(3'b000, 32'd6, 32'd7, 5'd3, 32'd42);
    exp_res_q.delete(); exp_tag_q.delete(); exp_lat_q.delete();
    repeat (5) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 64'(out_valid), 64'd0);
    chk("async rst out_result", 64'(out_result), 64'd0);
    chk("async rst out_tag", 64'(out_tag), 64'd0);
    chk("async rst in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run("MUL after reset", 3'b000, 32'd3, 32'd4, 5'd2, 32'd12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
